// File: rtl/fetch_pkg.sv
// Shared types and default widths for the 9-bit processor fetch stage.
package fetch_pkg;
  localparam int DEF_PC_W      = 10;
  localparam int DEF_INSTR_W   = 9;
  localparam int DEF_LUT_IDX_W = 4;
  localparam logic [DEF_INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {IDLE, RUN, HALT_PEND, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: control inputs, ROM port, LUT write port and decode-side outputs.
interface fetch_if #(
  parameter int PC_W      = fetch_pkg::DEF_PC_W,
  parameter int INSTR_W   = fetch_pkg::DEF_INSTR_W,
  parameter int LUT_IDX_W = fetch_pkg::DEF_LUT_IDX_W
);
  logic                 start;
  logic                 stall;
  logic                 branch_en;
  logic [LUT_IDX_W-1:0] branch_idx;
  logic                 lut_we;
  logic [LUT_IDX_W-1:0] lut_waddr;
  logic [PC_W-1:0]      lut_wdata;
  logic [PC_W-1:0]      imem_addr;
  logic [INSTR_W-1:0]   imem_rdata;
  logic [INSTR_W-1:0]   instr_out;
  logic [PC_W-1:0]      pc_out;
  logic                 instr_valid;
  logic                 done;

  modport master (
    input  start, stall, branch_en, branch_idx, lut_we, lut_waddr, lut_wdata, imem_rdata,
    output imem_addr, instr_out, pc_out, instr_valid, done
  );
  modport slave (
    output start, stall, branch_en, branch_idx, lut_we, lut_waddr, lut_wdata, imem_rdata,
    input  imem_addr, instr_out, pc_out, instr_valid, done
  );
endinterface

// File: rtl/branch_lut.sv
// Branch-target register file: one synchronous write port, one asynchronous read port.
module branch_lut #(
  parameter int PC_W  = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [PC_W-1:0]  rdata
);
  logic [2**IDX_W-1:0][PC_W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  // Read sees the pre-edge contents, so a same-edge write to the branch index is not forwarded.
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, ROM addressing, IF output register, LUT branches and HALT detection.
module fetch_unit import fetch_pkg::*; #(
  parameter int PC_W      = DEF_PC_W,
  parameter int INSTR_W   = DEF_INSTR_W,
  parameter int LUT_IDX_W = DEF_LUT_IDX_W,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_INSTR
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
);
  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_out_q, pc_out_d;
  logic               vld_q, vld_d;
  logic               done_q, done_d;
  logic [PC_W-1:0]    lut_rdata;

  branch_lut #(.PC_W(PC_W), .IDX_W(LUT_IDX_W)) u_lut (
    .clk   (clk),
    .rst_n (reset),
    .we    (bus.lut_we),
    .waddr (bus.lut_waddr),
    .wdata (bus.lut_wdata),
    .raddr (bus.branch_idx),
    .rdata (lut_rdata)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    vld_d    = vld_q;
    done_d   = done_q;
    if (bus.start) begin
      state_d = IDLE;
      pc_d    = '0;
      vld_d   = 1'b0;
      done_d  = 1'b0;
    end else if (!bus.stall) begin
      unique case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (bus.branch_en) begin
            // Squash the word fetched down the fall-through path.
            pc_d  = lut_rdata;
            vld_d = 1'b0;
          end else begin
            instr_d  = bus.imem_rdata;
            pc_out_d = pc_q;
            vld_d    = 1'b1;
            if (bus.imem_rdata == HALT_WORD) state_d = HALT_PEND;
            else                             pc_d    = pc_q + PC_W'(1);
          end
        end
        HALT_PEND: begin
          state_d = HALT;
          vld_d   = 1'b0;
          done_d  = 1'b1;
        end
        HALT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      pc_out_q <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.instr_valid = vld_q;
  assign bus.done        = done_q;
endmodule
